// File: rtl/tbird_pkg.sv
// tbird_pkg: shared mode encoding and request arbitration for the tail-light sequencer
package tbird_pkg;

    // bit 1 is the FSM l input and bit 0 is r, so the mode outputs are plain state bits
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b10,
        RIGHT  = 2'b01,
        HAZARD = 2'b11
    } mode_e;

    // both stalks at once is treated as a hazard request; IDLE stands for "no request"
    function automatic mode_e eff_req(input logic left, input logic right, input logic hazard);
        return (hazard || (left && right)) ? HAZARD : left ? LEFT : right ? RIGHT : IDLE;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: divides clk down to a one-cycle lamp step enable
module step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic load,
    output logic step
);

    localparam int DW = $clog2(STEP_DIV);
    localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;

    assign step = en && !clr && div_cnt_q == LAST;

    // clr holds the count at zero through the restart cycle; load zeroes it on a preempting edge
    always_comb begin
        div_cnt_d = (!en || clr || load || div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
    end

    // divider count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/tbird_lamp_ctrl.sv
// tbird_lamp_ctrl: turns driver stalk requests into paced l/r mode inputs for the tail-light FSM
module tbird_lamp_ctrl
    import tbird_pkg::*;
#(
    parameter int STEP_DIV    = 4,
    parameter int SWEEP_LEN   = 4,
    parameter int HOLD_SWEEPS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         left_req,
    input  logic                         right_req,
    input  logic                         hazard_req,
    output logic                         l,
    output logic                         r,
    output logic                         step,
    output logic                         restart,
    output logic [$clog2(SWEEP_LEN)-1:0] phase,
    output logic                         busy
);

    localparam int PW = $clog2(SWEEP_LEN);
    localparam int HW = $clog2(HOLD_SWEEPS + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SWEEP_LEN - 1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_SWEEPS);

    mode_e         state_q, state_d, req;
    logic [PW-1:0] phase_q, phase_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          restart_q, restart_d;
    logic          sweep_end;

    assign l       = state_q inside {LEFT, HAZARD};
    assign r       = state_q inside {RIGHT, HAZARD};
    assign busy    = state_q != IDLE;
    assign restart = restart_q;
    assign phase   = phase_q;

    step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .clr   (restart_q),
        .load  (restart_d),
        .step  (step)
    );

    // next mode: entry from idle, hazard preemption, otherwise decisions only at the sweep end
    always_comb begin
        req       = eff_req(left_req, right_req, hazard_req);
        sweep_end = step && phase_q == LAST_PHASE;
        state_d   = state_q;
        phase_d   = step ? ((phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1)) : phase_q;
        hold_d    = hold_q;
        restart_d = 1'b0;
        if (state_q == IDLE) begin
            if (req != IDLE) begin
                state_d   = req;
                phase_d   = '0;
                hold_d    = HOLD_INIT;
                restart_d = 1'b1;
            end
        end else if (state_q != HAZARD && req == HAZARD) begin
            state_d   = HAZARD;
            phase_d   = '0;
            hold_d    = HOLD_INIT;
            restart_d = 1'b1;
        end else if (sweep_end) begin
            if (req == state_q) begin
                hold_d = HOLD_INIT;
            end else if (req != IDLE) begin
                state_d   = req;
                hold_d    = HOLD_INIT;
                restart_d = 1'b1;
            end else if (hold_q == HW'(1)) begin
                state_d   = IDLE;
                hold_d    = '0;
                restart_d = 1'b1;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
    end

    // mode, sweep position, hold budget and restart pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            hold_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            restart_q <= restart_d;
        end
    end

endmodule

// File: tb/tb_tbird_lamp_ctrl.sv
// tb_tbird_lamp_ctrl: randomized and directed checks of the lamp sequencer against a timeline model
module tb_tbird_lamp_ctrl;

    localparam int SD = 4;
    localparam int SL = 4;
    localparam int HS = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       left_req = 1'b0;
    logic       right_req = 1'b0;
    logic       hazard_req = 1'b0;
    logic       l, r, step, restart, busy;
    logic [1:0] phase;

    int compared = 0;
    int mismatched = 0;

    // model: mode 0 idle / 1 left / 2 right / 3 hazard; m_t counts cycles since the last restart
    int   m_mode = 0;
    int   m_t = 0;
    int   m_hold = 0;
    logic m_restart = 1'b0;

    always #5 clk = ~clk;

    tbird_lamp_ctrl #(.STEP_DIV(SD), .SWEEP_LEN(SL), .HOLD_SWEEPS(HS)) dut (
        .clk        (clk),
        .reset      (reset),
        .left_req   (left_req),
        .right_req  (right_req),
        .hazard_req (hazard_req),
        .l          (l),
        .r          (r),
        .step       (step),
        .restart    (restart),
        .phase      (phase),
        .busy       (busy)
    );

    function automatic logic [6:0] obs();
        return {l, r, step, restart, phase, busy};
    endfunction

    // steps fall every SD cycles after a restart; the phase shown is the count of completed steps
    function automatic logic [6:0] exp_vec();
        logic el, er, es;
        int   ph;
        el = m_mode == 1 || m_mode == 3;
        er = m_mode == 2 || m_mode == 3;
        es = m_mode != 0 && m_t > 0 && m_t % SD == 0;
        ph = (m_mode == 0 || m_t == 0) ? 0 : ((m_t - 1) / SD) % SL;
        return {el, er, es, m_restart, 2'(ph), m_mode != 0};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_t = 0;
        m_hold = 0;
        m_restart = 1'b0;
    endtask

    task automatic model_tick();
        int   req;
        logic st, se;
        req = (hazard_req || (left_req && right_req)) ? 3 : left_req ? 1 : right_req ? 2 : 0;
        st = m_mode != 0 && m_t > 0 && m_t % SD == 0;
        se = st && m_t % (SD * SL) == 0;
        m_restart = 1'b0;
        if (m_mode == 0) begin
            if (req != 0) begin
                m_mode = req; m_t = 0; m_hold = HS; m_restart = 1'b1;
            end
        end else if ((m_mode == 1 || m_mode == 2) && req == 3) begin
            m_mode = 3; m_t = 0; m_hold = HS; m_restart = 1'b1;
        end else if (se && req == m_mode) begin
            m_hold = HS; m_t++;
        end else if (se && req != 0) begin
            m_mode = req; m_t = 0; m_hold = HS; m_restart = 1'b1;
        end else if (se && m_hold == 1) begin
            m_mode = 0; m_t = 0; m_hold = 0; m_restart = 1'b1;
        end else begin
            if (se) m_hold--;
            m_t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        left_req = 1'b0;
        right_req = 1'b0;
        hazard_req = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        left_req = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obs() !== 7'd0) begin
                mismatched++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs(), 7'd0);
            end
        end
        reset = 1'b1;
        tick();
        compared++;
        if ({l, r, restart, busy} !== 4'b1011) begin
            mismatched++;
            $display("FAIL reset_release: got l,r,restart,busy=%b want 1011", {l, r, restart, busy});
        end
        n = 0;
        do begin
            tick();
            n++;
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL reset_first_step t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end while (!step && n < 10);
        compared++;
        if (n != SD) begin
            mismatched++;
            $display("FAIL reset_step_latency: got %0d cycles want %0d", n, SD);
        end
    endtask

    task automatic test_left_release();
        int steps, busy_cyc, n;
        steps = 0;
        busy_cyc = 0;
        n = 0;
        apply_reset();
        left_req = 1'b1;
        while ((n < 20 || busy) && n < 120) begin
            if (n == 20) left_req = 1'b0;
            tick();
            n++;
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL left_release t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
            if (step) begin
                compared++;
                if (phase !== 2'(steps % SL)) begin
                    mismatched++;
                    $display("FAIL left_release_phase step %0d: got %0d want %0d", steps, phase, steps % SL);
                end
                steps++;
            end
            if (busy) busy_cyc++;
        end
        compared++;
        if (steps != 2 * SL) begin
            mismatched++;
            $display("FAIL left_release_steps: got %0d want %0d", steps, 2 * SL);
        end
        compared++;
        if (busy_cyc != 1 + 2 * SD * SL || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL left_release_busy: got %0d cycles busy=%b want %0d busy=0", busy_cyc, busy, 1 + 2 * SD * SL);
        end
    endtask

    task automatic test_hazard_preempt();
        int n;
        apply_reset();
        right_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL hazard_setup t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end while (phase != 2'd2 && n < 50);
        hazard_req = 1'b1;
        tick();
        compared++;
        if ({l, r, phase, restart} !== 5'b11001) begin
            mismatched++;
            $display("FAIL hazard_preempt: got l,r,phase,restart=%b want 11001", {l, r, phase, restart});
        end
        n = 0;
        do begin
            tick();
            n++;
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL hazard_run t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end while (!step && n < 10);
        compared++;
        if (n != SD) begin
            mismatched++;
            $display("FAIL hazard_step_latency: got %0d cycles want %0d", n, SD);
        end
    endtask

    task automatic test_both_stalks();
        apply_reset();
        left_req = 1'b1;
        right_req = 1'b1;
        tick();
        compared++;
        if ({l, r, busy, restart} !== 4'b1111) begin
            mismatched++;
            $display("FAIL both_stalks: got l,r,busy,restart=%b want 1111", {l, r, busy, restart});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL both_stalks_run t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_left_to_right();
        int         n;
        logic       prev_step;
        logic [1:0] prev_phase;
        apply_reset();
        left_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (phase != 2'd1 && n < 50);
        left_req = 1'b0;
        right_req = 1'b1;
        n = 0;
        do begin
            prev_step = step;
            prev_phase = phase;
            tick();
            n++;
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL left_to_right t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end while (!restart && n < 40);
        compared++;
        if ({l, r, prev_step, prev_phase} !== 5'b01111) begin
            mismatched++;
            $display("FAIL left_to_right_switch: got l,r,prev_step,prev_phase=%b want 01111", {l, r, prev_step, prev_phase});
        end
    endtask

    task automatic test_flicker();
        int n, restarts;
        apply_reset();
        left_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (phase != 2'd1 && n < 50);
        left_req = 1'b0;
        repeat (3) tick();
        left_req = 1'b1;
        restarts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL flicker t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
            if (restart) restarts++;
        end
        compared++;
        if (restarts != 0 || {l, r, busy} !== 3'b101) begin
            mismatched++;
            $display("FAIL flicker_stay: got restarts=%0d l,r,busy=%b want 0 and 101", restarts, {l, r, busy});
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        compared++;
        if (obs() !== 7'd0) begin
            mismatched++;
            $display("FAIL async_reset: got %b want %b", obs(), 7'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) left_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) right_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) hazard_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                compared++;
                if (obs() !== exp_vec()) begin
                    mismatched++;
                    $display("FAIL random_reset t=%0t: got %b want %b", $time, obs(), exp_vec());
                end
                @(negedge clk);
                reset = 1'b1;
            end
            tick();
            compared++;
            if (obs() !== exp_vec()) begin
                mismatched++;
                $display("FAIL random t=%0t: got %b want %b", $time, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_left_release();
        test_hazard_preempt();
        test_both_stalks();
        test_left_to_right();
        test_flicker();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
